// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction-fetch stage: PC, single-outstanding imem request,
//            response skid buffer and registered IF/ID slot with flush.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] jump_addr,
    input  logic        id_ready,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus_4,
    output logic [31:0] if_id_instr
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;

    logic        slot_free;
    logic        req_fire;
    logic [31:0] jump_aligned;

    assign jump_aligned    = jump_addr & ~32'h3;
    assign slot_free       = !ifid_valid_q || id_ready;
    assign imem_req_valid  = !rst && (state_q == FETCH) && !flush;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign imem_addr       = pc_q;
    assign if_id_valid     = ifid_valid_q;
    assign if_id_pc        = ifid_pc_q;
    assign if_id_pc_plus_4 = ifid_pc_q + 32'd4;
    assign if_id_instr     = ifid_instr_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        skid_pc_d    = skid_pc_q;
        skid_data_d  = skid_data_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;

        // Consumption empties the slot unless a new instruction replaces it below.
        if (ifid_valid_q && id_ready) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end

        if (flush) begin
            pc_d         = jump_aligned;
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            skid_pc_d    = 32'h0;
            skid_data_d  = 32'h0;
            case (state_q)
                WAIT:    state_d = imem_rsp_valid ? FETCH : DROP;
                DROP:    state_d = DROP;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (req_fire) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (slot_free) begin
                            ifid_valid_d = 1'b1;
                            ifid_pc_d    = req_pc_q;
                            ifid_instr_d = imem_rsp_data;
                            state_d      = FETCH;
                        end else begin
                            skid_pc_d   = req_pc_q;
                            skid_data_d = imem_rsp_data;
                            state_d     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = skid_pc_q;
                        ifid_instr_d = skid_data_q;
                        state_d      = FETCH;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            req_pc_q     <= 32'h0;
            skid_pc_q    <= 32'h0;
            skid_data_q  <= 32'h0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            skid_pc_q    <= skid_pc_d;
            skid_data_q  <= skid_data_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed vector table plus randomized scoreboard run for fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic        id_ready = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus_4;
    logic [31:0] if_id_instr;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .jump_addr       (jump_addr),
        .id_ready        (id_ready),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus_4 (if_id_pc_plus_4),
        .if_id_instr     (if_id_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic [31:0] ja;
        logic        rdy;
        logic        qr;
        logic        rv;
        logic [31:0] rd;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
        logic [31:0] e_in;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    vec_t tv[$];
    sb_t  sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic fl, input logic [31:0] ja, input logic rdy, input logic qr,
                       input logic rv, input logic [31:0] rd, input logic e_rv,
                       input logic [31:0] e_addr, input logic e_v, input logic [31:0] e_pc,
                       input logic [31:0] e_in);
        vec_t v;
        v.fl = fl; v.ja = ja; v.rdy = rdy; v.qr = qr; v.rv = rv; v.rd = rd;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc; v.e_in = e_in;
        tv.push_back(v);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'h0, imem_req_valid}, 32'h0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_ifid_valid"}, {31'h0, if_id_valid}, 32'h0);
        chk({tag, "_ifid_pc"}, if_id_pc, 32'h0);
        chk({tag, "_ifid_pc4"}, if_id_pc_plus_4, 32'h4);
        chk({tag, "_ifid_instr"}, if_id_instr, NOP);
    endtask

    initial begin
        logic        pending;
        int          cnt;
        logic [31:0] pend_data;
        logic [31:0] exp_pc;
        logic        prev_flush;
        logic        fire;
        int          consumed;
        sb_t         e;

        //      fl  ja            rdy qr  rv  rd             e_rv e_addr        e_v e_pc          e_in
        add(0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        NOP);
        add(0, 32'h0,        1, 1, 1, 32'h00500093, 0, 32'h4,        0, 32'h0,        NOP);
        add(0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h4,        1, 32'h0,        32'h00500093);
        add(0, 32'h0,        0, 1, 1, 32'h00400113, 0, 32'h8,        0, 32'h0,        NOP);
        add(0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h8,        1, 32'h4,        32'h00400113);
        add(0, 32'h0,        0, 1, 1, 32'h00300193, 0, 32'hC,        1, 32'h4,        32'h00400113);
        add(0, 32'h0,        0, 1, 0, 32'h0,        0, 32'hC,        1, 32'h4,        32'h00400113);
        add(0, 32'h0,        1, 1, 0, 32'h0,        0, 32'hC,        1, 32'h4,        32'h00400113);
        add(0, 32'h0,        0, 1, 0, 32'h0,        1, 32'hC,        1, 32'h8,        32'h00300193);
        add(0, 32'h0,        1, 1, 1, 32'h00200213, 0, 32'h10,       1, 32'h8,        32'h00300193);
        add(0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h10,       1, 32'hC,        32'h00200213);
        add(1, 32'h100,      1, 1, 0, 32'h0,        0, 32'h14,       0, 32'h0,        NOP);
        add(0, 32'h0,        1, 1, 0, 32'h0,        0, 32'h100,      0, 32'h0,        NOP);
        add(0, 32'h0,        1, 1, 1, 32'hDEAD0010, 0, 32'h100,      0, 32'h0,        NOP);
        add(0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h100,      0, 32'h0,        NOP);
        add(1, 32'h203,      1, 1, 1, 32'h11111111, 0, 32'h104,      0, 32'h0,        NOP);
        add(0, 32'h0,        1, 0, 0, 32'h0,        1, 32'h200,      0, 32'h0,        NOP);
        add(0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h200,      0, 32'h0,        NOP);
        add(0, 32'h0,        0, 1, 1, 32'h00100293, 0, 32'h204,      0, 32'h0,        NOP);
        add(0, 32'h0,        0, 1, 0, 32'h0,        1, 32'h204,      1, 32'h200,      32'h00100293);
        add(0, 32'h0,        0, 1, 1, 32'h0BAD0204, 0, 32'h208,      1, 32'h200,      32'h00100293);
        add(1, 32'h300,      1, 1, 0, 32'h0,        0, 32'h208,      1, 32'h200,      32'h00100293);
        add(1, 32'hFFFFFFFE, 1, 0, 0, 32'h0,        0, 32'h300,      0, 32'h0,        NOP);
        add(0, 32'h0,        1, 1, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h0,        NOP);
        add(0, 32'h0,        1, 1, 1, 32'h00700313, 0, 32'h0,        0, 32'h0,        NOP);
        add(0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        1, 32'hFFFFFFFC, 32'h00700313);

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            flush          = tv[i].fl;
            jump_addr      = tv[i].ja;
            id_ready       = tv[i].rdy;
            imem_req_ready = tv[i].qr;
            imem_rsp_valid = tv[i].rv;
            imem_rsp_data  = tv[i].rd;
            #1;
            chk($sformatf("v%0d_req_valid", i), {31'h0, imem_req_valid}, {31'h0, tv[i].e_rv});
            chk($sformatf("v%0d_addr", i), imem_addr, tv[i].e_addr);
            chk($sformatf("v%0d_ifid_valid", i), {31'h0, if_id_valid}, {31'h0, tv[i].e_v});
            chk($sformatf("v%0d_ifid_instr", i), if_id_instr, tv[i].e_in);
            if (tv[i].e_v) begin
                chk($sformatf("v%0d_ifid_pc", i), if_id_pc, tv[i].e_pc);
                chk($sformatf("v%0d_ifid_pc4", i), if_id_pc_plus_4, tv[i].e_pc + 32'd4);
            end
        end

        // Asynchronous reset with a live IF/ID slot.
        @(negedge clk);
        flush = 1'b0; id_ready = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        #1;
        chk("pre_midreset_valid", {31'h0, if_id_valid}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("post_reset_addr", imem_addr, 32'h0);

        // Randomized run against a memory model and scoreboard.
        pending    = 1'b0;
        cnt        = 0;
        pend_data  = 32'h0;
        exp_pc     = 32'h0;
        prev_flush = 1'b0;
        consumed   = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            fire = 1'b0;
            if (pending) begin
                if (cnt == 0) begin
                    fire    = 1'b1;
                    pending = 1'b0;
                end else begin
                    cnt--;
                end
            end
            flush          = ($urandom_range(0, 19) == 0);
            jump_addr      = $urandom;
            id_ready       = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 2) != 0);
            imem_rsp_valid = fire;
            imem_rsp_data  = fire ? pend_data : $urandom;
            #1;
            if (prev_flush)
                chk("after_flush_invalid", {31'h0, if_id_valid}, 32'h0);
            if (!if_id_valid)
                chk("empty_slot_nop", if_id_instr, NOP);
            if (imem_req_valid) begin
                chk("one_outstanding", {31'h0, (pending || fire)}, 32'h0);
                chk("req_addr", imem_addr, exp_pc);
            end
            if (if_id_valid && id_ready && !flush) begin
                if (sb.size() == 0) begin
                    chk("stale_instr_pc", if_id_pc, 32'hFFFF_FFFF ^ if_id_pc);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", if_id_pc, e.pc);
                    chk("sb_pc4", if_id_pc_plus_4, e.pc + 32'd4);
                    chk("sb_instr", if_id_instr, e.instr);
                    consumed++;
                end
            end
            if (flush) begin
                sb.delete();
                exp_pc = jump_addr & ~32'h3;
            end else if (imem_req_valid && imem_req_ready) begin
                pend_data = $urandom;
                e.pc      = exp_pc;
                e.instr   = pend_data;
                sb.push_back(e);
                pending   = 1'b1;
                cnt       = $urandom_range(0, 2);
                exp_pc    = exp_pc + 32'd4;
            end
            prev_flush = flush;
        end
        chk("progress", {31'h0, (consumed > 20)}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
